datapath_core: RTL

//  Parametrised single-bus CPU datapath: register file, HI/LO/Y/Z/PC, bus source mux and ALU.

---
 rtl/dp_pkg.sv | 45 ++++
 rtl/iter_muldiv.sv | 138 +++++++++++++
 rtl/datapath_core.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/dp_pkg.sv
// Shared definitions for the single-bus datapath: ALU opcodes, bus-source and
// bus-load bit positions, and the multiply/divide sequencer states.
package dp_pkg;

   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4;
   localparam logic [4:0] OP_AND  = 5'd5;
   localparam logic [4:0] OP_OR   = 5'd6;
   localparam logic [4:0] OP_SHR  = 5'd7;
   localparam logic [4:0] OP_SHRA = 5'd8;
   localparam logic [4:0] OP_SHL  = 5'd9;
   localparam logic [4:0] OP_ROR  = 5'd10;
   localparam logic [4:0] OP_ROL  = 5'd11;
   localparam logic [4:0] OP_MUL  = 5'd15;
   localparam logic [4:0] OP_DIV  = 5'd16;
   localparam logic [4:0] OP_NEG  = 5'd17;
   localparam logic [4:0] OP_NOT  = 5'd18;

   localparam int SP_HI     = 0;
   localparam int SP_LO     = 1;
   localparam int SP_ZH     = 2;
   localparam int SP_ZL     = 3;
   localparam int SP_PC     = 4;
   localparam int SP_MDR    = 5;
   localparam int SP_INPORT = 6;
   localparam int SP_IMM    = 7;
   localparam int SP_W      = 8;

   localparam int LD_HI = 0;
   localparam int LD_LO = 1;
   localparam int LD_Y  = 2;
   localparam int LD_PC = 3;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_RUN  = 2'd1,
      MD_FIX  = 2'd2
   } md_state_t;

   // True when more than one bit of the source-select vector is set.
   function automatic logic multi_hot(input logic [63:0] v);
      return |(v & (v - 64'd1));
   endfunction

endpackage

// File: rtl/iter_muldiv.sv
// Iterative signed multiply (shift-add) and divide (restoring) on magnitudes,
// one bit per cycle, with the last step and sign fix folded into the FIX cycle.
module iter_muldiv
   import dp_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_div,
   input  logic [DATA_W-1:0] i_a,
   input  logic [DATA_W-1:0] i_b,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_wr,
   output logic              o_div0,
   output logic [DATA_W-1:0] o_res_hi,
   output logic [DATA_W-1:0] o_res_lo
);

   localparam int CNT_W = $clog2(DATA_W);

   md_state_t         r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_done;
   logic              r_div0;
   logic [DATA_W-1:0] r_hi;
   logic [DATA_W-1:0] r_lo;
   logic [DATA_W-1:0] r_m;
   logic              r_div;
   logic              r_neg_q;
   logic              r_neg_r;

   logic                w_idle;
   logic                w_dz;
   logic                w_load;
   logic [DATA_W-1:0]   w_a_mag;
   logic [DATA_W-1:0]   w_b_mag;
   logic [DATA_W:0]     w_trial;
   logic [DATA_W:0]     w_diff;
   logic [DATA_W:0]     w_sum;
   logic [DATA_W-1:0]   w_hi_nx;
   logic [DATA_W-1:0]   w_lo_nx;
   logic [2*DATA_W-1:0] w_prod;

   assign w_idle  = (r_state == MD_IDLE);
   assign w_dz    = w_idle & i_start & i_div & (i_b == '0);
   assign w_load  = w_idle & i_start & ~w_dz;
   assign w_a_mag = i_a[DATA_W-1] ? -i_a : i_a;
   assign w_b_mag = i_b[DATA_W-1] ? -i_b : i_b;

   // One iteration: r_hi is accumulator/remainder, r_lo is multiplier/quotient.
   always_comb begin
      w_trial = {r_hi, r_lo[DATA_W-1]};
      w_diff  = w_trial - {1'b0, r_m};
      w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
      if (r_div) begin
         if (!w_diff[DATA_W]) begin
            w_hi_nx = w_diff[DATA_W-1:0];
            w_lo_nx = {r_lo[DATA_W-2:0], 1'b1};
         end else begin
            w_hi_nx = w_trial[DATA_W-1:0];
            w_lo_nx = {r_lo[DATA_W-2:0], 1'b0};
         end
      end else begin
         w_hi_nx = w_sum[DATA_W:1];
         w_lo_nx = {w_sum[0], r_lo[DATA_W-1:1]};
      end
   end

   always_comb begin
      w_prod = {w_hi_nx, w_lo_nx};
      if (r_neg_q) w_prod = -w_prod;
      if (w_dz) begin
         o_res_hi = i_a;
         o_res_lo = '1;
      end else if (r_div) begin
         o_res_hi = r_neg_r ? -w_hi_nx : w_hi_nx;
         o_res_lo = r_neg_q ? -w_lo_nx : w_lo_nx;
      end else begin
         o_res_hi = w_prod[2*DATA_W-1:DATA_W];
         o_res_lo = w_prod[DATA_W-1:0];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= MD_IDLE;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_div0  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            MD_IDLE: begin
               if (w_dz) begin
                  r_done <= 1'b1;
                  r_div0 <= 1'b1;
               end else if (w_load) begin
                  r_cnt   <= CNT_W'(DATA_W - 1);
                  r_state <= MD_RUN;
               end
            end
            MD_RUN: begin
               r_cnt <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) r_state <= MD_FIX;
            end
            MD_FIX: begin
               r_done  <= 1'b1;
               r_state <= MD_IDLE;
            end
            default: r_state <= MD_IDLE;
         endcase
      end
   end

   // Working registers carry no reset; they are always loaded before use.
   always_ff @(posedge i_clk) begin
      if (w_load) begin
         r_hi    <= '0;
         r_lo    <= w_a_mag;
         r_m     <= w_b_mag;
         r_div   <= i_div;
         r_neg_q <= i_a[DATA_W-1] ^ i_b[DATA_W-1];
         r_neg_r <= i_a[DATA_W-1];
      end else if (!w_idle) begin
         r_hi <= w_hi_nx;
         r_lo <= w_lo_nx;
      end
   end

   assign o_busy = ~w_idle;
   assign o_done = r_done;
   assign o_wr   = (r_state == MD_FIX) | w_dz;
   assign o_div0 = r_div0;

endmodule

// File: rtl/datapath_core.sv
// Single-bus CPU datapath: register file, HI/LO/Y/Z/PC, OR-based bus source mux,
// single-cycle ALU, and an iterative multiply/divide unit.
module datapath_core
   import dp_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16,
   parameter int OP_W     = 5
) (
   input  logic                clock,
   input  logic                clear,
   input  logic [NUM_REGS-1:0] reg_out,
   input  logic [NUM_REGS-1:0] reg_in,
   input  logic                ba_out,
   input  logic [SP_W-1:0]     sp_out,
   input  logic [3:0]          ld_en,
   input  logic                inc_pc,
   input  logic [DATA_W-1:0]   mdr_data,
   input  logic [DATA_W-1:0]   inport_data,
   input  logic [DATA_W-1:0]   imm,
   input  logic [OP_W-1:0]     alu_op,
   input  logic                alu_start,
   output logic                alu_busy,
   output logic                alu_done,
   output logic                div0,
   output logic [DATA_W-1:0]   bus,
   output logic [DATA_W-1:0]   pc_q,
   output logic                bus_err
);

   localparam int SH_W  = $clog2(DATA_W);
   localparam int SRC_W = NUM_REGS + SP_W;

   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic [DATA_W-1:0] r_hi;
   logic [DATA_W-1:0] r_lo;
   logic [DATA_W-1:0] r_y;
   logic [DATA_W-1:0] r_zh;
   logic [DATA_W-1:0] r_zl;
   logic [DATA_W-1:0] r_pc;
   logic              r_done;
   logic              r_bus_err;

   logic [DATA_W-1:0]        w_bus;
   logic [SRC_W-1:0]         w_srcs;
   logic                     w_multi;
   logic                     w_accept;
   logic                     w_is_md;
   logic                     w_sc_wr;
   logic [DATA_W-1:0]        w_alu_res;
   logic                     w_alu_valid;
   logic [SH_W-1:0]          w_sh;
   logic signed [DATA_W-1:0] w_y_s;
   logic [2*DATA_W-1:0]      w_ror;
   logic [2*DATA_W-1:0]      w_rol;
   logic                     w_md_busy;
   logic                     w_md_done;
   logic                     w_md_wr;
   logic                     w_md_div0;
   logic [DATA_W-1:0]        w_md_hi;
   logic [DATA_W-1:0]        w_md_lo;

   // R0 in base-address mode contributes zero but still counts as a source.
   always_comb begin
      w_bus = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (reg_out[i] && !(i == 0 && ba_out)) w_bus = w_bus | r_regs[i];
      end
      if (sp_out[SP_HI])     w_bus = w_bus | r_hi;
      if (sp_out[SP_LO])     w_bus = w_bus | r_lo;
      if (sp_out[SP_ZH])     w_bus = w_bus | r_zh;
      if (sp_out[SP_ZL])     w_bus = w_bus | r_zl;
      if (sp_out[SP_PC])     w_bus = w_bus | r_pc;
      if (sp_out[SP_MDR])    w_bus = w_bus | mdr_data;
      if (sp_out[SP_INPORT]) w_bus = w_bus | inport_data;
      if (sp_out[SP_IMM])    w_bus = w_bus | imm;
   end

   assign w_srcs   = {sp_out, reg_out};
   assign w_multi  = multi_hot(64'(w_srcs));
   assign w_is_md  = (alu_op == OP_W'(OP_MUL)) | (alu_op == OP_W'(OP_DIV));
   assign w_accept = alu_start & ~w_md_busy & ~alu_done;
   assign w_sc_wr  = w_accept & ~w_is_md & w_alu_valid;
   assign w_sh     = w_bus[SH_W-1:0];
   assign w_y_s    = r_y;

   always_comb begin
      w_alu_res   = '0;
      w_alu_valid = 1'b1;
      w_ror       = {r_y, r_y} >> w_sh;
      w_rol       = {r_y, r_y} << w_sh;
      case (alu_op)
         OP_W'(OP_ADD):  w_alu_res = r_y + w_bus;
         OP_W'(OP_SUB):  w_alu_res = r_y - w_bus;
         OP_W'(OP_AND):  w_alu_res = r_y & w_bus;
         OP_W'(OP_OR):   w_alu_res = r_y | w_bus;
         OP_W'(OP_SHR):  w_alu_res = r_y >> w_sh;
         OP_W'(OP_SHRA): w_alu_res = w_y_s >>> w_sh;
         OP_W'(OP_SHL):  w_alu_res = r_y << w_sh;
         OP_W'(OP_ROR):  w_alu_res = w_ror[DATA_W-1:0];
         OP_W'(OP_ROL):  w_alu_res = w_rol[2*DATA_W-1:DATA_W];
         OP_W'(OP_NEG):  w_alu_res = -w_bus;
         OP_W'(OP_NOT):  w_alu_res = ~w_bus;
         default:        w_alu_valid = 1'b0;
      endcase
   end

   iter_muldiv #(
      .DATA_W (DATA_W)
   ) u_muldiv (
      .i_clk    (clock),
      .i_rst_n  (clear),
      .i_start  (w_accept & w_is_md),
      .i_div    (alu_op == OP_W'(OP_DIV)),
      .i_a      (r_y),
      .i_b      (w_bus),
      .o_busy   (w_md_busy),
      .o_done   (w_md_done),
      .o_wr     (w_md_wr),
      .o_div0   (w_md_div0),
      .o_res_hi (w_md_hi),
      .o_res_lo (w_md_lo)
   );

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_y       <= '0;
         r_zh      <= '0;
         r_zl      <= '0;
         r_pc      <= '0;
         r_done    <= 1'b0;
         r_bus_err <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (reg_in[i]) r_regs[i] <= w_bus;
         end
         if (ld_en[LD_HI]) r_hi <= w_bus;
         if (ld_en[LD_LO]) r_lo <= w_bus;
         if (ld_en[LD_Y])  r_y  <= w_bus;
         if (ld_en[LD_PC])  r_pc <= w_bus;
         else if (inc_pc)   r_pc <= r_pc + DATA_W'(1);
         if (w_md_wr) begin
            r_zh <= w_md_hi;
            r_zl <= w_md_lo;
         end else if (w_sc_wr) begin
            r_zh <= '0;
            r_zl <= w_alu_res;
         end
         r_done <= w_accept & ~w_is_md;
         if (w_multi) r_bus_err <= 1'b1;
      end
   end

   assign bus      = w_bus;
   assign pc_q     = r_pc;
   assign alu_busy = w_md_busy;
   assign alu_done = r_done | w_md_done;
   assign div0     = w_md_div0;
   assign bus_err  = r_bus_err;

endmodule
